// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: modifier tracking, key-event FIFO with modifier snapshots and,
// when PS2_KBD_LED_UPDATE_EN is defined, the lock-LED update sequence over the host-to-device path.
module ps2_kbd_ctrl #(
    parameter int FIFO_AW     = 3,
    parameter int ACK_TIMEOUT = 500000,
    parameter int TO_W        = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_down,
    input  logic       key_up,
    input  logic [7:0] scan_code,
    output logic       shift,
    output logic       caps_lock,
    output logic       num_lock,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic [2:0] ev_mods,
    output logic       ev_ovf,
    output logic       tx_valid,
    output logic [7:0] tx_byte,
    input  logic       tx_ready,
    output logic       led_err
);

    localparam int         DEPTH     = 2 ** FIFO_AW;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_NUM    = 8'h77;
    localparam logic [7:0] SC_ACK    = 8'hFA;

    logic lsh, rsh, caps_held, num_held;
    logic caps_tgl, num_tgl, key_up_eff, push_req;

    // ps2_unit never strobes both; if it did, the make code wins.
    assign key_up_eff = key_up & ~key_down;
    assign caps_tgl   = key_down && (scan_code == SC_CAPS) && !caps_held;
    assign num_tgl    = key_down && (scan_code == SC_NUM)  && !num_held;
    assign push_req   = key_down && (scan_code != SC_LSHIFT) && (scan_code != SC_RSHIFT) &&
                        (scan_code != SC_CAPS) && (scan_code != SC_NUM) && (scan_code != SC_ACK);

    // NOTE: sequential state always uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsh       <= 1'b0;
            rsh       <= 1'b0;
            caps_held <= 1'b0;
            num_held  <= 1'b0;
            caps_lock <= 1'b0;
            num_lock  <= 1'b0;
        end else begin
            if (key_down) begin
                if (scan_code == SC_LSHIFT) lsh       <= 1'b1;
                if (scan_code == SC_RSHIFT) rsh       <= 1'b1;
                if (scan_code == SC_CAPS)   caps_held <= 1'b1;
                if (scan_code == SC_NUM)    num_held  <= 1'b1;
            end else if (key_up_eff) begin
                if (scan_code == SC_LSHIFT) lsh       <= 1'b0;
                if (scan_code == SC_RSHIFT) rsh       <= 1'b0;
                if (scan_code == SC_CAPS)   caps_held <= 1'b0;
                if (scan_code == SC_NUM)    num_held  <= 1'b0;
            end
            if (caps_tgl) caps_lock <= ~caps_lock;
            if (num_tgl)  num_lock  <= ~num_lock;
        end
    end

    assign shift = lsh | rsh;

    // Event FIFO: pointers carry one extra bit to tell full from empty.
    logic [10:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             empty, full, pop, push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = ev_ready && !empty;
    assign push  = push_req && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ev_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            ev_ovf <= push_req && full && !pop;
        end
    end

    // NOTE: storage array is deliberately not reset; pointers alone define validity,
    // and leaving it out of reset lets it map onto plain RAM/register files.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {scan_code, shift, caps_lock, num_lock};
    end

    assign ev_valid = !empty;
    assign ev_code  = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]][10:3];
    assign ev_mods  = empty ? 3'b000 : mem[rd_ptr[FIFO_AW-1:0]][2:0];

`ifdef PS2_KBD_LED_UPDATE_EN
    typedef enum logic [2:0] {
        IDLE, SEND_CMD, WAIT_ACK1, SEND_LED, WAIT_ACK2
    } led_state_t;

    led_state_t      state, state_next;
    logic [TO_W-1:0] to_cnt;
    logic            pend, led_byte_ld, err_set, ack, timeout, waiting;
    logic [7:0]      led_byte;

    assign ack     = key_down && (scan_code == SC_ACK);
    assign waiting = (state == WAIT_ACK1) || (state == WAIT_ACK2);
    assign timeout = (to_cnt == TO_W'(ACK_TIMEOUT - 1));

    // NOTE: every output of this block gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        tx_valid    = 1'b0;
        tx_byte     = 8'h00;
        err_set     = 1'b0;
        led_byte_ld = 1'b0;
        case (state)
            IDLE: if (pend) state_next = SEND_CMD;
            SEND_CMD: begin
                tx_valid = 1'b1;
                tx_byte  = 8'hED;
                if (tx_ready) state_next = WAIT_ACK1;
            end
            WAIT_ACK1: begin
                if (ack) begin
                    state_next  = SEND_LED;
                    led_byte_ld = 1'b1;
                end else if (timeout) begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end
            end
            SEND_LED: begin
                tx_valid = 1'b1;
                tx_byte  = led_byte;
                if (tx_ready) state_next = WAIT_ACK2;
            end
            WAIT_ACK2: begin
                if (ack) begin
                    state_next = IDLE;
                end else if (timeout) begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            to_cnt   <= '0;
            pend     <= 1'b0;
            led_byte <= 8'h00;
            led_err  <= 1'b0;
        end else begin
            state   <= state_next;
            led_err <= err_set;
            to_cnt  <= (waiting && state_next == state) ? to_cnt + 1'b1 : '0;
            if (led_byte_ld) led_byte <= {5'b0, caps_lock, num_lock, 1'b0};
            // A toggle arriving while IDLE launches outranks the clear, so it is not lost.
            if (caps_tgl || num_tgl)     pend <= 1'b1;
            else if (state == IDLE)      pend <= 1'b0;
        end
    end
`else
    logic unused_tx_ready;
    assign unused_tx_ready = tx_ready;
    assign tx_valid        = 1'b0;
    assign tx_byte         = 8'h00;
    assign led_err         = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a key-level reference model predicts modifiers,
// queue contents and overflow; a monitor compares whenever the DUT presents them.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 8;

    logic       clk, rst;
    logic       key_down, key_up, ev_ready, tx_ready;
    logic [7:0] scan_code;
    logic       shift, caps_lock, num_lock, ev_valid, ev_ovf, tx_valid, led_err;
    logic [7:0] ev_code, tx_byte;
    logic [2:0] ev_mods;

    int checks = 0;
    int errors = 0;

    ps2_kbd_ctrl #(.FIFO_AW(3), .ACK_TIMEOUT(16), .TO_W(20)) dut (
        .clk(clk), .rst(rst), .key_down(key_down), .key_up(key_up), .scan_code(scan_code),
        .shift(shift), .caps_lock(caps_lock), .num_lock(num_lock),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_mods(ev_mods),
        .ev_ovf(ev_ovf), .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
        .led_err(led_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: key-level view of held keys, lock toggles and the event queue.
    typedef struct packed { logic [7:0] code; logic [2:0] mods; } ev_t;
    ev_t  sb[$];
    bit   held[256];
    bit   m_caps, m_num, m_ovf, m_pop, m_qable;
    int   m_count;
    logic [2:0] m_mods;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            foreach (held[i]) held[i] = 1'b0;
            m_caps = 0; m_num = 0; m_ovf = 0; m_count = 0;
            sb.delete();
        end else begin
            m_pop   = ev_ready && (m_count > 0);
            m_mods  = {held[8'h12] | held[8'h59], m_caps, m_num};
            m_ovf   = 0;
            m_qable = 0;
            if (key_down) begin
                case (scan_code)
                    8'h12, 8'h59: held[scan_code] = 1'b1;
                    8'h58: begin if (!held[8'h58]) m_caps = ~m_caps; held[8'h58] = 1'b1; end
                    8'h77: begin if (!held[8'h77]) m_num  = ~m_num;  held[8'h77] = 1'b1; end
                    8'hFA: ;
                    default: m_qable = 1;
                endcase
                if (m_qable) begin
                    if (m_count < DEPTH || m_pop) begin
                        sb.push_back('{code: scan_code, mods: m_mods});
                        m_count++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end else if (key_up) begin
                held[scan_code] = 1'b0;
            end
            if (m_pop) m_count--;
        end
    end

    // Monitor: compares DUT outputs against the model mid-cycle, pops on consumer handshake.
    always @(negedge clk) begin
        if (rst) begin
            check("ev_valid", ev_valid, m_count > 0);
            if (ev_valid && sb.size() > 0) begin
                check("ev_code", ev_code, sb[0].code);
                check("ev_mods", ev_mods, sb[0].mods);
            end
            if (ev_ready && sb.size() > 0) void'(sb.pop_front());
            check("shift", shift, held[8'h12] | held[8'h59]);
            check("caps_lock", caps_lock, m_caps);
            check("num_lock", num_lock, m_num);
            check("ev_ovf", ev_ovf, m_ovf);
`ifndef PS2_KBD_LED_UPDATE_EN
            check("tx_valid_off", tx_valid, 0);
            check("led_err_off", led_err, 0);
`endif
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_shift"}, shift, 0);
        check({tag, "_caps"}, caps_lock, 0);
        check({tag, "_num"}, num_lock, 0);
        check({tag, "_ev_valid"}, ev_valid, 0);
        check({tag, "_ev_code"}, ev_code, 0);
        check({tag, "_ev_mods"}, ev_mods, 0);
        check({tag, "_ev_ovf"}, ev_ovf, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_byte"}, tx_byte, 0);
        check({tag, "_led_err"}, led_err, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        key_down = 0; key_up = 0; scan_code = 8'h00; ev_ready = 0; tx_ready = 0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_down(input logic [7:0] code);
        key_down = 1; scan_code = code;
        @(posedge clk); #1;
        key_down = 0;
    endtask

    task automatic pulse_up(input logic [7:0] code);
        key_up = 1; scan_code = code;
        @(posedge clk); #1;
        key_up = 0;
    endtask

    task automatic drain();
        ev_ready = 1;
        repeat (DEPTH + 3) @(posedge clk);
        #1 ev_ready = 0;
        check("drain_empty", ev_valid, 0);
    endtask

    task automatic wait_tx(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 50);
        check({name, "_seen"}, tx_valid, 1);
    endtask

    logic [7:0] pool [16] = '{8'h12, 8'h59, 8'h58, 8'h77, 8'hFA, 8'h1C, 8'h1B, 8'h23,
                              8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h5A, 8'h66};

    initial begin
        int ovf_cnt;
        rst = 1'b1;
        #2;
        do_reset();

        // Plain key-down on an empty queue.
        pulse_down(8'h1C);
        check("t1_valid", ev_valid, 1);
        check("t1_code", ev_code, 8'h1C);
        check("t1_mods", ev_mods, 3'b000);
        drain();

        // Shift snapshot taken before the following key.
        pulse_down(8'h12);
        check("t2_shift_on", shift, 1);
        pulse_down(8'h1C);
        pulse_up(8'h12);
        check("t2_shift_off", shift, 0);
        pulse_down(8'h1C);
        check("t2_head_mods", ev_mods, 3'b100);
        drain();

        // Caps auto-repeat ignored until release.
        repeat (3) pulse_down(8'h58);
        check("t3_caps_on", caps_lock, 1);
        pulse_up(8'h58);
        pulse_down(8'h58);
        check("t3_caps_off", caps_lock, 0);
        pulse_up(8'h58);
        drain();

        // Overflow on the ninth push; a push alongside a pop is not an overflow.
        do_reset();
        ovf_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            pulse_down(8'h20 + 8'(i));
            ovf_cnt += int'(ev_ovf);
        end
        check("t4_ovf_count", ovf_cnt, 1);
        ev_ready = 1;
        pulse_down(8'h2D);
        ev_ready = 0;
        check("t4_full_pop_no_ovf", ev_ovf, 0);
        drain();

        // Randomized traffic with a bursty consumer.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 9);
            scan_code = pool[$urandom_range(0, 15)];
            key_down  = (r < 4) || (r == 6);
            key_up    = (r == 4) || (r == 5) || (r == 6);
            ev_ready  = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        key_down = 0; key_up = 0; ev_ready = 0;
        drain();

`ifdef PS2_KBD_LED_UPDATE_EN
        // Full LED sequence with prompt acks.
        do_reset();
        tx_ready = 1;
        pulse_down(8'h58);
        wait_tx("t5_cmd");
        check("t5_cmd_byte", tx_byte, 8'hED);
        @(posedge clk); #1;
        pulse_down(8'hFA);
        wait_tx("t5_led");
        check("t5_led_byte", tx_byte, 8'h04);
        @(posedge clk); #1;
        pulse_down(8'hFA);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_idle_tx", tx_valid, 0);
            check("t5_no_event", ev_valid, 0);
        end
        @(posedge clk); #1;

        // Ack timeout, then reset during WAIT_ACK2.
        do_reset();
        tx_ready = 0;
        pulse_down(8'h58);
        pulse_up(8'h58);
        wait_tx("t6_cmd");
        for (int i = 0; i < 3; i++) begin
            check("t6_cmd_stable", tx_byte, 8'hED);
            @(negedge clk);
        end
        tx_ready = 1;
        @(posedge clk); #1;
        tx_ready = 0;
        repeat (15) @(posedge clk);
        @(negedge clk) check("t6_err_early", led_err, 0);
        @(negedge clk) check("t6_err_pulse", led_err, 1);
        @(negedge clk) check("t6_err_end", led_err, 0);
        check("t6_idle_tx", tx_valid, 0);
        @(posedge clk); #1;
        tx_ready = 1;
        pulse_down(8'h77);
        pulse_up(8'h77);
        wait_tx("t6_cmd2");
        @(posedge clk); #1;
        pulse_down(8'hFA);
        wait_tx("t6_led");
        check("t6_led_byte", tx_byte, 8'h06);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_all_zero("t6_midreset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
